// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - State codes, reset constants and IF/ID layout for the fetch stage
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } ifid_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } skid_t;

   localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pc_plus4: 32'h0, instr: INSTR_NOP};

   // Branch wins over jump; both targets are forced word-aligned.
   function automatic logic [31:0] redirect_target(
      input logic        pcsrc,
      input logic [31:0] pcbranch,
      input logic [31:0] pc_plus4,
      input logic [31:0] instr
   );
      if (pcsrc)
         return {pcbranch[31:2], 2'b00};
      return {pc_plus4[31:28], instr[25:0], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register: enable, synchronous clear to bubble, async reset
module if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  logic  clr,
   input  ifid_t d,
   output ifid_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= IFID_BUBBLE;
      else if (clr)
         q <= IFID_BUBBLE;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Instruction fetch: PC, next-PC selection, imem handshake, skid buffer and IF/ID
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_d,
   input  logic        pcsrc_d,
   input  logic [31:0] pcbranch_d,
   input  logic        jump_d,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d
);

   fetch_state_t state, state_n;
   logic [31:0]  pc_n;
   logic [31:0]  redir_pc, redir_pc_n;
   skid_t        skid, skid_n;
   logic [31:0]  pc_plus4_f;
   logic         redirect;
   logic [31:0]  target;
   logic         ifid_en, ifid_clr;
   ifid_t        ifid_d, ifid_q;
   logic         unused_bits;

   assign pc_plus4_f = pc_f + 32'd4;
   assign redirect   = valid_d & ~stall_d & (pcsrc_d | jump_d);
   assign target     = redirect_target(pcsrc_d, pcbranch_d, pc_plus4_d, instr_d);

   assign imem_req  = ~rst & (state != HOLD);
   assign imem_addr = pc_f;

   assign instr_d    = ifid_q.instr;
   assign pc_plus4_d = ifid_q.pc_plus4;
   assign valid_d    = ifid_q.valid;

   assign unused_bits = ^pcbranch_d[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH;
         pc_f     <= RESET_PC;
         redir_pc <= RESET_PC;
         skid     <= '0;
      end else begin
         state    <= state_n;
         pc_f     <= pc_n;
         redir_pc <= redir_pc_n;
         skid     <= skid_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc_f;
      redir_pc_n = redir_pc;
      skid_n     = skid;
      ifid_en    = 1'b0;
      ifid_clr   = 1'b0;
      ifid_d     = '{valid: 1'b1, pc_plus4: pc_plus4_f, instr: imem_rdata};

      unique case (state)
         FETCH: begin
            if (redirect && imem_ready) begin
               pc_n     = target;
               ifid_clr = 1'b1;
            end else if (redirect) begin
               // Request already on the bus; its data must be swallowed first.
               redir_pc_n = target;
               ifid_clr   = 1'b1;
               state_n    = DISCARD;
            end else if (imem_ready && !stall_d) begin
               ifid_en = 1'b1;
               pc_n    = pc_plus4_f;
            end else if (imem_ready) begin
               skid_n  = '{instr: imem_rdata, pc_plus4: pc_plus4_f};
               pc_n    = pc_plus4_f;
               state_n = HOLD;
            end else if (!stall_d) begin
               ifid_clr = 1'b1;
            end
         end

         HOLD: begin
            if (!stall_d) begin
               state_n = FETCH;
               if (redirect) begin
                  pc_n     = target;
                  ifid_clr = 1'b1;
               end else begin
                  ifid_en = 1'b1;
                  ifid_d  = '{valid: 1'b1, pc_plus4: skid.pc_plus4, instr: skid.instr};
               end
            end
         end

         DISCARD: begin
            if (imem_ready) begin
               pc_n    = redir_pc;
               state_n = FETCH;
            end
         end

         default: begin
            state_n = FETCH;
         end
      endcase
   end

   if_id_reg u_if_id_reg (
      .clk (clk),
      .rst (rst),
      .en  (ifid_en),
      .clr (ifid_clr),
      .d   (ifid_d),
      .q   (ifid_q)
   );

endmodule
